// File: rtl/axi2ahb_wctrl.sv
// AXI-to-AHB bridge write-channel sequencer.
// Owns the AW handshake, beat grants and the AHB address phase.
module axi2ahb_wctrl #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [AXI_ID_WIDTH-1:0]   AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  output logic [AXI_ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  input  logic                      HREADY,
  output logic [AXI_ID_WIDTH-1:0]   cmd_id_o,
  output logic                      cmd_error_o,
  input  logic                      ctrl_wdata_last_i,
  output logic                      ctrl_wdata_valid_o,
  input  logic                      ctrl_wdata_ready_i
);

  localparam int MAXSZ = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic                      init_q;
  logic                      drain_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_nxt;
  logic [AXI_ADDR_WIDTH-1:0] inc;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic [2:0]                size_q;
  logic                      fixed_q;
  logic                      unsup_q;
  logic                      over_q;
  logic                      xing_q;
  logic                      err_q;
  logic                      fire;
  logic                      aw_hs;
  logic                      issue;
  logic                      early;
  logic                      unsup_aw;

  assign unsup_aw = (AWSIZE > 3'(MAXSZ)) | AWBURST[1];
  assign inc      = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
  assign addr_nxt = addr_q + inc;
  assign issue    = fire & ~unsup_q & ~over_q;
  assign early    = fire & ctrl_wdata_last_i & (cnt_q < len_q);

  assign cmd_id_o    = id_q;
  assign cmd_error_o = err_q | early;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, AW acceptance and beat grant
  always_comb begin
    state_d            = state_q;
    AWREADY            = 1'b0;
    ctrl_wdata_valid_o = 1'b0;
    fire               = 1'b0;
    aw_hs              = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        AWREADY = init_q;
        if (AWVALID && init_q) begin
          aw_hs   = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        ctrl_wdata_valid_o = HREADY;
        fire = HREADY & ctrl_wdata_ready_i;
        if (fire && ctrl_wdata_last_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, beat tracking and error flag
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q  <= 1'b0;
      drain_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      fixed_q <= 1'b0;
      unsup_q <= 1'b0;
      over_q  <= 1'b0;
      xing_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
      if (aw_hs) begin
        id_q    <= AWID;
        addr_q  <= AWADDR;
        len_q   <= AWLEN;
        size_q  <= AWSIZE;
        fixed_q <= (AWBURST == 2'b00);
        unsup_q <= unsup_aw;
        err_q   <= unsup_aw;
        cnt_q   <= '0;
        over_q  <= 1'b0;
        xing_q  <= 1'b0;
      end
      if (fire) begin
        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        if (early) err_q <= 1'b1;
        if (!ctrl_wdata_last_i && cnt_q == len_q) begin
          err_q  <= 1'b1;
          over_q <= 1'b1;
        end
      end
      if (issue && !fixed_q) begin
        addr_q <= addr_nxt;
        xing_q <= addr_nxt[AXI_ADDR_WIDTH-1:10]
               != addr_q[AXI_ADDR_WIDTH-1:10];
      end
      if (state_q == S_DRAIN && drain_q) err_q <= 1'b0;
    end
  end

  // AHB address phase, advancing only while HREADY is high
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      HADDR  <= '0;
      HTRANS <= T_IDLE;
      HWRITE <= 1'b0;
      HSIZE  <= '0;
      HBURST <= B_SINGLE;
    end else if (HREADY) begin
      if (issue) begin
        HADDR  <= addr_q;
        HTRANS <= (cnt_q == 8'd0 || fixed_q || xing_q)
                ? T_NONSEQ : T_SEQ;
        HWRITE <= 1'b1;
        HSIZE  <= size_q;
        HBURST <= (len_q == 8'd0 || fixed_q) ? B_SINGLE : B_INCR;
      end else begin
        HTRANS <= T_IDLE;
        HWRITE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi2ahb_wctrl.sv
// Directed bench for axi2ahb_wctrl.
// Linear stimulus with immediate-assertion checks.
module tb_axi2ahb_wctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [0:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HREADY;
  logic [0:0]  cmd_id_o;
  logic        cmd_error_o;
  logic        last;
  logic        gnt;
  logic        wvalid;

  int checks = 0;
  int errors = 0;

  axi2ahb_wctrl dut (
    .ACLK               (ACLK),
    .ARESETN            (ARESETN),
    .AWID               (AWID),
    .AWADDR             (AWADDR),
    .AWLEN              (AWLEN),
    .AWSIZE             (AWSIZE),
    .AWBURST            (AWBURST),
    .AWVALID            (AWVALID),
    .AWREADY            (AWREADY),
    .HADDR              (HADDR),
    .HTRANS             (HTRANS),
    .HWRITE             (HWRITE),
    .HSIZE              (HSIZE),
    .HBURST             (HBURST),
    .HREADY             (HREADY),
    .cmd_id_o           (cmd_id_o),
    .cmd_error_o        (cmd_error_o),
    .ctrl_wdata_last_i  (last),
    .ctrl_wdata_valid_o (gnt),
    .ctrl_wdata_ready_i (wvalid)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hsize", 32'(HSIZE), 0);
    chk("rst_hburst", 32'(HBURST), 0);
    chk("rst_awready", 32'(AWREADY), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_id", 32'(cmd_id_o), 0);
    chk("rst_err", 32'(cmd_error_o), 0);
  endtask

  task automatic do_aw(input logic [0:0] id, input logic [31:0] ad,
                       input logic [7:0] ln, input logic [2:0] sz,
                       input logic [1:0] bu);
    int n;
    AWID = id; AWADDR = ad; AWLEN = ln;
    AWSIZE = sz; AWBURST = bu; AWVALID = 1'b1;
    #1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin
      @(posedge ACLK);
      #2;
      n++;
    end
    chk("aw_ready", 32'(AWREADY), 1);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic beat(input logic lst, input logic [1:0] tr,
                      input logic [31:0] ad, input logic er);
    wvalid = 1'b1;
    last = lst;
    #1;
    chk("wgrant", 32'(gnt), 1);
    chk("err_beat", 32'(cmd_error_o), 32'(er));
    tick();
    chk("htrans", 32'(HTRANS), 32'(tr));
    chk("hwrite", 32'(HWRITE), 32'(tr != 2'b00));
    if (tr != 2'b00) chk("haddr", HADDR, ad);
    wvalid = 1'b0;
    last = 1'b0;
  endtask

  task automatic drain(input logic er, input logic [0:0] id);
    #1;
    chk("drain1_awready", 32'(AWREADY), 0);
    chk("drain1_err", 32'(cmd_error_o), 32'(er));
    chk("drain1_id", 32'(cmd_id_o), 32'(id));
    tick();
    chk("drain2_awready", 32'(AWREADY), 0);
    chk("drain2_err", 32'(cmd_error_o), 32'(er));
    chk("drain2_id", 32'(cmd_id_o), 32'(id));
    chk("drain2_htrans", 32'(HTRANS), 0);
    tick();
    chk("idle_awready", 32'(AWREADY), 1);
    chk("idle_err", 32'(cmd_error_o), 0);
  endtask

  initial begin
    ARESETN = 1'b0; HREADY = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0;
    AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    last = 1'b0; wvalid = 1'b0;
    #12;
    chk_reset();
    ARESETN = 1'b1;
    #1;
    chk("post_rel_awready", 32'(AWREADY), 0);
    tick();
    chk("first_edge_awready", 32'(AWREADY), 1);

    // INCR len=3 at 0x100
    do_aw(1'b1, 32'h100, 8'd3, 3'd2, 2'b01);
    beat(1'b0, 2'b10, 32'h100, 1'b0);
    chk("t1_hburst", 32'(HBURST), 1);
    chk("t1_hsize", 32'(HSIZE), 2);
    beat(1'b0, 2'b11, 32'h104, 1'b0);
    beat(1'b0, 2'b11, 32'h108, 1'b0);
    beat(1'b1, 2'b11, 32'h10C, 1'b0);
    drain(1'b0, 1'b1);

    // INCR across 1 KB boundary
    do_aw(1'b0, 32'h3F8, 8'd3, 3'd2, 2'b01);
    beat(1'b0, 2'b10, 32'h3F8, 1'b0);
    beat(1'b0, 2'b11, 32'h3FC, 1'b0);
    beat(1'b0, 2'b10, 32'h400, 1'b0);
    beat(1'b1, 2'b11, 32'h404, 1'b0);
    drain(1'b0, 1'b0);

    // FIXED len=2
    do_aw(1'b1, 32'h20, 8'd2, 3'd2, 2'b00);
    beat(1'b0, 2'b10, 32'h20, 1'b0);
    chk("t3_hburst", 32'(HBURST), 0);
    beat(1'b0, 2'b10, 32'h20, 1'b0);
    beat(1'b1, 2'b10, 32'h20, 1'b0);
    drain(1'b0, 1'b1);

    // Oversized beat: consumed but never issued
    do_aw(1'b0, 32'h40, 8'd1, 3'd3, 2'b01);
    #1;
    chk("t4_err_entry", 32'(cmd_error_o), 1);
    beat(1'b0, 2'b00, 32'h0, 1'b1);
    beat(1'b1, 2'b00, 32'h0, 1'b1);
    drain(1'b1, 1'b0);

    // Early WLAST on beat 1 of 4
    do_aw(1'b1, 32'h200, 8'd3, 3'd2, 2'b01);
    beat(1'b0, 2'b10, 32'h200, 1'b0);
    beat(1'b1, 2'b11, 32'h204, 1'b1);
    drain(1'b1, 1'b1);

    // Missing WLAST: len=1, last on beat 3
    do_aw(1'b0, 32'h300, 8'd1, 3'd2, 2'b01);
    beat(1'b0, 2'b10, 32'h300, 1'b0);
    beat(1'b0, 2'b11, 32'h304, 1'b0);
    beat(1'b0, 2'b00, 32'h0, 1'b1);
    beat(1'b1, 2'b00, 32'h0, 1'b1);
    drain(1'b1, 1'b0);

    // HREADY stall then reset mid-burst
    do_aw(1'b1, 32'h500, 8'd3, 3'd2, 2'b01);
    beat(1'b0, 2'b10, 32'h500, 1'b0);
    beat(1'b0, 2'b11, 32'h504, 1'b0);
    HREADY = 1'b0; wvalid = 1'b1;
    #1;
    chk("stall1_gnt", 32'(gnt), 0);
    chk("stall1_htrans", 32'(HTRANS), 3);
    chk("stall1_haddr", HADDR, 32'h504);
    tick();
    chk("stall2_gnt", 32'(gnt), 0);
    chk("stall2_htrans", 32'(HTRANS), 3);
    chk("stall2_haddr", HADDR, 32'h504);
    tick();
    HREADY = 1'b1;
    chk("stall3_htrans", 32'(HTRANS), 3);
    chk("stall3_haddr", HADDR, 32'h504);
    beat(1'b0, 2'b11, 32'h508, 1'b0);
    ARESETN = 1'b0;
    #1;
    chk_reset();
    ARESETN = 1'b1;
    #1;
    chk("rel2_awready", 32'(AWREADY), 0);
    tick();
    chk("rel2_edge_awready", 32'(AWREADY), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi2ahb_wctrl.md
# axi2ahb_wctrl

Write-channel sequencer of the AXI-to-AHB bridge. Accepts one AXI write command (AW) at a time and tracks the beat count. Drives the AHB address phase (HADDR/HTRANS/HBURST/HSIZE/HWRITE) and gates beat acceptance in `axi2ahb_wdata` through its `ctrl_wdata_*` handshake. Holds `cmd_id_o`/`cmd_error_o` stable until `axi2ahb_wdata` has pushed the B response.

## Interface
- AXI_ID_WIDTH, 1, AWID/BID width
- AXI_ADDR_WIDTH, 32, AWADDR/HADDR width
- AXI_DATA_WIDTH, 32, data bus width; bytes per beat = AXI_DATA_WIDTH/8 (power of two)

- ACLK  in  1  clock; all state updates on posedge
- ARESETN  in  1  asynchronous reset, active low
- AWID  in  AXI_ID_WIDTH  write ID
- AWADDR  in  AXI_ADDR_WIDTH  start byte address
- AWLEN  in  8  beats minus one
- AWSIZE  in  3  log2 bytes per beat
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- AWVALID / AWREADY  in / out  1  AW handshake
- HADDR  out  AXI_ADDR_WIDTH  AHB address
- HTRANS  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
- HWRITE  out  1  1 when HTRANS != IDLE
- HSIZE  out  3  latched AWSIZE
- HBURST  out  3  000 SINGLE, 001 INCR
- HREADY  in  1  AHB ready
- cmd_id_o  out  AXI_ID_WIDTH  latched AWID, to wdata `cmd_id_i`
- cmd_error_o  out  1  transaction error, to wdata `cmd_error_i`
- ctrl_wdata_last_i  in  1  WLAST from wdata
- ctrl_wdata_valid_o  out  1  beat grant (becomes WREADY)
- ctrl_wdata_ready_i  in  1  WVALID from wdata

## Operation
- FSM states and transitions:
  - IDLE: AWREADY=1. AW handshake latches ID, addr, len, size, burst; beat counter `cnt`=0; goes to DATA.
  - DATA: `ctrl_wdata_valid_o = HREADY`. A beat fires on valid & ready & HREADY.
  - DRAIN: 2 cycles, counted by a 1-bit counter; then IDLE.
- Unsupported command (AWSIZE > log2(AXI_DATA_WIDTH/8), or AWBURST = WRAP or 11):
  - `cmd_error_o` = 1 from DATA entry until DRAIN exit.
  - All beats are still consumed but issue HTRANS IDLE.
- Address phase per supported beat:
  - Beat 0: NONSEQ. Later beats: SEQ.
  - Exceptions forced to NONSEQ: FIXED burst (address constant), and any beat whose INCR address crosses a 1 KB boundary (addr[9:0] wraps).
  - INCR address increment = 1<<AWSIZE, computed at AXI_ADDR_WIDTH and wrapping modulo 2^AXI_ADDR_WIDTH.
  - HBURST = SINGLE if AWLEN=0 or FIXED, else INCR.
- Beat accounting:
  - Normal end: beat with `cnt == AWLEN` and last=1 goes to DRAIN.
  - Early WLAST (last=1, `cnt < AWLEN`): sets `cmd_error_o`, goes to DRAIN, and no further address phases are issued.
  - Missing WLAST (`cnt == AWLEN`, last=0): sets `cmd_error_o` and stays in DATA. Extra beats issue HTRANS IDLE until a beat with last=1, then DRAIN.
  - `cnt` saturates at 255.
- Error flag is sticky within a transaction and cleared on entry to IDLE.
- Reset mid-transaction aborts immediately to IDLE. No response is generated.

## Timing
- Reset values:
  - AWREADY=0, set on the first ACLK edge after ARESETN release.
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0.
  - cmd_id_o=0, cmd_error_o=0, ctrl_wdata_valid_o=0.
- Address phase outputs are registered and update only on edges where HREADY=1; they hold while HREADY=0.
  - Beat fired in cycle t: address phase presented in t+1 and data phase in t+2. This matches the 2-stage WDATA→HWDATA pipeline in wdata.
  - Edge with HREADY=1 and no beat fired: loads HTRANS=IDLE.
- AW handshake at edge e: DATA from e+1, so the first beat can fire in cycle e+1.
- Last beat fired in cycle t:
  - DRAIN occupies t+1 and t+2, covering wdata's `resp_valid` cycle.
  - IDLE and AWREADY=1 from t+3.
  - `cmd_id_o`/`cmd_error_o` are stable t..t+2.
- Minimum AW-to-AW spacing = AWLEN+4 cycles.
- No beat is granted while HREADY=0. Target slaves must be zero-wait in the data phase, because the wdata pipeline does not stall.

## Test plan
- AW{id=1, addr=0x100, len=3, size=2, INCR}, WVALID always high, HREADY=1 → HTRANS NONSEQ,SEQ,SEQ,SEQ at 0x100/104/108/10C; HBURST=INCR; BID=1, BRESP=00; AWREADY returns 3 cycles after last beat.
- INCR len=3 at addr=0x3F8 → beats at 0x3F8, 0x3FC NONSEQ/SEQ, then 0x400 NONSEQ, 0x404 SEQ.
- FIXED len=2 addr=0x20 → three NONSEQ SINGLE beats, all at 0x20.
- AWSIZE=3 on a 32-bit bus, len=1 → two beats consumed, HTRANS stays IDLE, BRESP=10.
- len=3 with WLAST on beat 1 → DRAIN after beat 1, BRESP=10, next AW accepted; len=1 with WLAST on beat 3 → beats 2–3 HTRANS IDLE, BRESP=10.
- HREADY low 2 cycles mid-burst → ctrl_wdata_valid_o=0 and HADDR/HTRANS held; ARESETN pulse mid-burst → all outputs at reset values, AWREADY=1 one edge after release.
